// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/add/sub/slt, iterative shift-add MUL and restoring DIV.
// Results leave through an OutValid/OutReady pair; HI carries MUL upper word or DIV remainder.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] HI,
  output logic             Zero,
  output logic             DivByZero,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready are both
  // high; the producer holds its payload stable until that edge.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1000;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   hi_q;
  logic               zero_q;
  logic               dbz_q;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  always_comb begin
    alu_res = '0;
    case (sel)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOP:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // acc = {partial product high, remaining multiplier bits}; shift right each step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (div_ge) div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
    else        div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    step_next = (state == S_MUL) ? mul_next : div_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opnd   <= '0;
      acc    <= '0;
      res_q  <= '0;
      hi_q   <= '0;
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (InValid) begin
            cnt <= '0;
            case (sel)
              OP_MUL: begin
                acc   <= {{WIDTH{1'b0}}, B};
                opnd  <= A;
                state <= S_MUL;
              end
              OP_DIV: begin
                if (B == '0) begin
                  res_q  <= '1;
                  hi_q   <= A;
                  zero_q <= 1'b0;
                  dbz_q  <= 1'b1;
                  state  <= S_DONE;
                end else begin
                  acc   <= {{WIDTH{1'b0}}, A};
                  opnd  <= B;
                  state <= S_DIV;
                end
              end
              default: begin
                res_q  <= alu_res;
                hi_q   <= '0;
                zero_q <= (alu_res == '0);
                dbz_q  <= 1'b0;
                state  <= S_DONE;
              end
            endcase
          end
        end
        S_MUL, S_DIV: begin
          acc <= step_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            res_q  <= step_next[WIDTH-1:0];
            hi_q   <= step_next[2*WIDTH-1:WIDTH];
            zero_q <= (step_next[WIDTH-1:0] == '0);
            dbz_q  <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (OutReady) begin
            dbz_q <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign InReady   = (state == S_IDLE);
  assign OutValid  = (state == S_DONE);
  assign Result    = res_q;
  assign HI        = hi_q;
  assign Zero      = zero_q;
  assign DivByZero = dbz_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed ops with hand-computed results, latency,
// backpressure hold and mid-operation reset.
module tb_alu_multicycle;

  localparam int W = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1000;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         dbz;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   sel;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Result;
  logic [W-1:0] HI;
  logic         Zero;
  logic         DivByZero;
  logic [1:0]   state_dbg;

  exp_t exp_q[$];
  exp_t cur;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic prev_ov = 1'b0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .sel(sel), .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .HI(HI), .Zero(Zero), .DivByZero(DivByZero),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  // drivers
  task automatic issue(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic [W-1:0] hi,
                       input logic dbz, input int lat);
    exp_t e;
    int n = 0;
    while (!InReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!InReady) begin
      chk("issue_timeout", 64'd0, 64'd1);
      return;
    end
    e.res  = res;
    e.hi   = hi;
    e.zero = (res == '0);
    e.dbz  = dbz;
    e.lat  = lat;
    e.acc  = cyc;
    exp_q.push_back(e);
    sel     = s;
    A       = a;
    B       = b;
    InValid = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(exp_q.size() == 0 && InReady) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (OutValid) begin
        if (!prev_ov) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
            chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
          end
        end
        chk("result",    64'(Result),    64'(cur.res));
        chk("hi",        64'(HI),        64'(cur.hi));
        chk("zero",      64'(Zero),      64'(cur.zero));
        chk("divbyzero", 64'(DivByZero), 64'(cur.dbz));
        chk("inready_busy", 64'(InReady), 64'd0);
      end
      prev_ov = OutValid;
    end
  end

  initial begin
    rst_n    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    A        = '0;
    B        = '0;
    sel      = OP_NOP;
    repeat (3) @(negedge clk);
    chk("rst_inready",  64'(InReady),   64'd1);
    chk("rst_outvalid", 64'(OutValid),  64'd0);
    chk("rst_result",   64'(Result),    64'd0);
    chk("rst_hi",       64'(HI),        64'd0);
    chk("rst_zero",     64'(Zero),      64'd0);
    chk("rst_dbz",      64'(DivByZero), 64'd0);
    chk("rst_state",    64'(state_dbg), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with explicit one-cycle turnaround
    issue(OP_ADD, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1);
    chk("add_outvalid", 64'(OutValid), 64'd1);
    @(negedge clk);
    chk("add_inready_after", 64'(InReady), 64'd1);
    wait_done();

    // single-cycle ops
    issue(OP_SUB, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1);                        wait_done();
    issue(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'd0, 1'b0, 1);                wait_done();
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1);                wait_done();
    issue(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1);                wait_done();
    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'd0, 1'b0, 1); wait_done();
    issue(OP_OR,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 32'd0, 1'b0, 1); wait_done();
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1);                wait_done();
    issue(OP_NOP, 32'd123, 32'd456, 32'd0, 32'd0, 1'b0, 1);                    wait_done();
    issue(4'b0101, 32'd123, 32'd456, 32'd0, 32'd0, 1'b0, 1);                   wait_done();

    // multiply
    issue(OP_MUL, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 32'h0000_0001, 1'b0, 33); wait_done();
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33); wait_done();
    issue(OP_MUL, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 1'b0, 33);                         wait_done();

    // divide
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);                    wait_done();
    issue(OP_DIV, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 33);                     wait_done();
    issue(OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);       wait_done();
    issue(OP_DIV, 32'h0000_0055, 32'd0, 32'hFFFF_FFFF, 32'h0000_0055, 1'b1, 1); wait_done();

    // backpressure: result must hold, new requests ignored
    OutReady = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      sel     = OP_ADD;
      A       = 32'd100;
      B       = 32'd100;
      InValid = 1'b1;
      @(negedge clk);
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    @(negedge clk);
    chk("bp_release_outvalid", 64'(OutValid), 64'd0);
    chk("bp_release_inready",  64'(InReady),  64'd1);
    repeat (3) @(negedge clk);
    chk("bp_ignored_outvalid", 64'(OutValid), 64'd0);

    // reset in the middle of a divide aborts it
    issue(OP_DIV, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_outvalid", 64'(OutValid), 64'd0);
    chk("abort_inready",  64'(InReady),  64'd1);
    chk("abort_result",   64'(Result),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_ADD, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
